// File: rtl/v_alu_pkg.sv
// Shared definitions for the vector ALU issue scheduler: opcodes, FSM states
// and the opcode-to-latency mapping.
package v_alu_pkg;

  localparam int unsigned VALU_OP_NOP  = 0;
  localparam int unsigned VALU_OP_VADD = 1;
  localparam int unsigned VALU_OP_VMUL = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Cycles the operands stay on the shared ALU; only VMUL gets the long path.
  function automatic int unsigned op_latency(input int unsigned opcode,
                                             input int unsigned add_lat,
                                             input int unsigned mul_lat);
    int unsigned lat;
    case (opcode)
      VALU_OP_VMUL:               lat = mul_lat;
      VALU_OP_NOP, VALU_OP_VADD:  lat = add_lat;
      default:                    lat = add_lat;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/v_rr_arbiter.sv
// NREQ-wide round-robin arbiter: grants the first requester at or after the
// pointer and advances the pointer past the winner when the grant is accepted.
module v_rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] r_ptr;

  function automatic logic [IDXW-1:0] wrap_idx(input int unsigned x);
    return IDXW'(x % NREQ);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[wrap_idx(32'(r_ptr) + i)]) begin
        o_any = 1'b1;
        o_idx = wrap_idx(32'(r_ptr) + i);
      end
    end
    o_grant = o_any ? (NREQ'(1) << o_idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= (o_idx == IDXW'(NREQ - 1)) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/v_alu_sched.sv
// Issue scheduler sharing one combinational vector ALU between NREQ slots:
// round-robin grant, opcode-dependent hold time, valid/ready writeback.
module v_alu_sched
  import v_alu_pkg::*;
#(
  parameter  int NREQ      = 2,
  parameter  int VALUOP_DW = 5,
  parameter  int VREG_DW   = 256,
  parameter  int VREG_AW   = 5,
  parameter  int ADD_LAT   = 1,
  parameter  int MUL_LAT   = 2,
  localparam int SRCW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*VALUOP_DW-1:0] req_opcode_i,
  input  logic [NREQ*VREG_DW-1:0]   req_v1_i,
  input  logic [NREQ*VREG_DW-1:0]   req_v2_i,
  input  logic [NREQ*VREG_AW-1:0]   req_vd_i,
  output logic [VALUOP_DW-1:0]      alu_opcode_o,
  output logic [VREG_DW-1:0]        alu_v1_o,
  output logic [VREG_DW-1:0]        alu_v2_o,
  input  logic [VREG_DW-1:0]        alu_result_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [VREG_DW-1:0]        wb_data_o,
  output logic [VREG_AW-1:0]        wb_vd_o,
  output logic [SRCW-1:0]           wb_src_o,
  output logic                      busy_o,
  output logic [31:0]               op_count_o
);

  localparam int MAXLAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  state_e               r_state, w_state_nxt;
  logic [CNTW-1:0]      r_cnt;
  logic [VALUOP_DW-1:0] r_opcode;
  logic [VREG_DW-1:0]   r_v1, r_v2, r_wb_data;
  logic [VREG_AW-1:0]   r_vd;
  logic [SRCW-1:0]      r_src;
  logic [31:0]          r_op_count;

  logic [NREQ-1:0]      w_grant;
  logic [SRCW-1:0]      w_idx;
  logic                 w_any, w_accept, w_exec;
  logic [VALUOP_DW-1:0] w_sel_op;
  int unsigned          w_lat;

  // Gated by rst so req_ready_o reads 0 while reset is held.
  assign w_accept = (r_state == ST_IDLE) && w_any && rst;
  assign w_sel_op = req_opcode_i[w_idx*VALUOP_DW +: VALUOP_DW];
  assign w_lat    = op_latency(32'(w_sel_op), ADD_LAT, MUL_LAT);

  v_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req_valid_i),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_state_nxt = ST_EXEC;
      ST_EXEC: if (r_cnt == '0)   w_state_nxt = ST_WB;
      ST_WB:   if (wb_ready_i)    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: the operand and result registers are plain flops, not storage
  // arrays, so they take the async reset and every output reads 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_opcode   <= '0;
      r_v1       <= '0;
      r_v2       <= '0;
      r_vd       <= '0;
      r_src      <= '0;
      r_wb_data  <= '0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opcode <= w_sel_op;
            r_v1     <= req_v1_i[w_idx*VREG_DW +: VREG_DW];
            r_v2     <= req_v2_i[w_idx*VREG_DW +: VREG_DW];
            r_vd     <= req_vd_i[w_idx*VREG_AW +: VREG_AW];
            r_src    <= w_idx;
            r_cnt    <= CNTW'(w_lat - 1);
          end
        end
        ST_EXEC: begin
          if (r_cnt != '0) r_cnt     <= r_cnt - 1'b1;
          else             r_wb_data <= alu_result_i;
        end
        ST_WB: begin
          if (wb_ready_i) r_op_count <= r_op_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // The ALU sees a NOP with zero operands whenever no op is executing.
  assign w_exec       = (r_state == ST_EXEC);
  assign alu_opcode_o = w_exec ? r_opcode : '0;
  assign alu_v1_o     = w_exec ? r_v1     : '0;
  assign alu_v2_o     = w_exec ? r_v2     : '0;

  assign req_ready_o  = w_accept ? w_grant : '0;
  assign wb_valid_o   = (r_state == ST_WB);
  assign wb_data_o    = r_wb_data;
  assign wb_vd_o      = r_vd;
  assign wb_src_o     = r_src;
  assign busy_o       = (r_state != ST_IDLE);
  assign op_count_o   = r_op_count;

endmodule

// File: tb/tb_v_alu_sched.sv
// Directed bench for v_alu_sched with a lane-wise (SEW=32) ALU model on the
// shared ALU port and hand-computed expected values.
module tb_v_alu_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid_i;
  logic [1:0]   req_ready_o;
  logic [9:0]   req_opcode_i;
  logic [511:0] req_v1_i, req_v2_i;
  logic [9:0]   req_vd_i;
  logic [4:0]   alu_opcode_o;
  logic [255:0] alu_v1_o, alu_v2_o, alu_result_i;
  logic         wb_valid_o, wb_ready_i;
  logic [255:0] wb_data_o;
  logic [4:0]   wb_vd_o;
  logic [0:0]   wb_src_o;
  logic         busy_o;
  logic [31:0]  op_count_o;

  int n_cmp = 0;
  int n_err = 0;

  v_alu_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_opcode_i),
    .req_v1_i     (req_v1_i),
    .req_v2_i     (req_v2_i),
    .req_vd_i     (req_vd_i),
    .alu_opcode_o (alu_opcode_o),
    .alu_v1_o     (alu_v1_o),
    .alu_v2_o     (alu_v2_o),
    .alu_result_i (alu_result_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_data_o    (wb_data_o),
    .wb_vd_o      (wb_vd_o),
    .wb_src_o     (wb_src_o),
    .busy_o       (busy_o),
    .op_count_o   (op_count_o)
  );

  always #5 clk = ~clk;

  // Shared ALU: eight 32-bit lanes, VADD/VMUL truncated to SEW, else 0.
  always_comb begin
    alu_result_i = '0;
    for (int l = 0; l < 8; l++) begin
      case (alu_opcode_o)
        5'd1: alu_result_i[l*32 +: 32] = alu_v1_o[l*32 +: 32] + alu_v2_o[l*32 +: 32];
        5'd2: alu_result_i[l*32 +: 32] = alu_v1_o[l*32 +: 32] * alu_v2_o[l*32 +: 32];
        default: alu_result_i[l*32 +: 32] = 32'd0;
      endcase
    end
  end

  function automatic logic [255:0] splat(input logic [31:0] x);
    return {8{x}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] vd);
    req_opcode_i[k*5 +: 5]     = op;
    req_v1_i[k*256 +: 256]     = splat(a);
    req_v2_i[k*256 +: 256]     = splat(b);
    req_vd_i[k*5 +: 5]         = vd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  logic [1:0]   gr[4];
  logic [0:0]   src_q[4];
  logic [255:0] dat_q[4];
  int           n_gr, n_wb;

  initial begin
    rst = 1'b0; req_valid_i = '0; req_opcode_i = '0; req_v1_i = '0;
    req_v2_i = '0; req_vd_i = '0; wb_ready_i = 1'b1;
    repeat (2) cyc();
    check("rst_busy", busy_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_op_count", op_count_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    rst = 1'b1;
    cyc();

    // Single VADD on slot0: 5 + 7 = 12 per lane, vd 3
    set_slot(0, 5'd1, 32'd5, 32'd7, 5'd3);
    req_valid_i = 2'b01;
    #1;
    check("add_ready", req_ready_o, 2'b01);
    check("add_idle_busy", busy_o, 0);
    cyc();
    req_valid_i = 2'b00;
    #1;
    check("add_exec_op", alu_opcode_o, 5'd1);
    check("add_exec_v1", alu_v1_o, splat(32'd5));
    check("add_exec_ready", req_ready_o, 2'b00);
    check("add_exec_wbv", wb_valid_o, 0);
    cyc();
    check("add_wb_valid", wb_valid_o, 1);
    check("add_wb_data", wb_data_o, splat(32'd12));
    check("add_wb_vd", wb_vd_o, 5'd3);
    check("add_wb_src", wb_src_o, 1'b0);
    check("add_wb_aluop", alu_opcode_o, 5'd0);
    cyc();
    check("add_count", op_count_o, 32'd1);
    check("add_done_busy", busy_o, 0);

    // VMUL on slot1: 0x10000 * 0x10000 truncates to 0, two EXEC cycles
    set_slot(1, 5'd2, 32'h10000, 32'h10000, 5'd9);
    req_valid_i = 2'b10;
    #1;
    check("mul_ready", req_ready_o, 2'b10);
    cyc();
    req_valid_i = 2'b00;
    #1;
    check("mul_exec1_op", alu_opcode_o, 5'd2);
    cyc();
    check("mul_exec2_op", alu_opcode_o, 5'd2);
    check("mul_exec2_wbv", wb_valid_o, 0);
    cyc();
    check("mul_wb_valid", wb_valid_o, 1);
    check("mul_wb_data", wb_data_o, 256'd0);
    check("mul_wb_src", wb_src_o, 1'b1);
    check("mul_wb_vd", wb_vd_o, 5'd9);
    cyc();
    check("mul_count", op_count_o, 32'd2);

    // Both slots requesting continuously: grants alternate 0,1,0,1
    set_slot(0, 5'd1, 32'd1, 32'd2, 5'd4);
    set_slot(1, 5'd1, 32'd10, 32'd20, 5'd5);
    req_valid_i = 2'b11;
    #1;
    n_gr = 0; n_wb = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_ready_o != 2'b00) begin
        if (n_gr < 4) gr[n_gr] = req_ready_o;
        n_gr++;
      end
      if (wb_valid_o) begin
        if (n_wb < 4) begin
          src_q[n_wb] = wb_src_o;
          dat_q[n_wb] = wb_data_o;
        end
        n_wb++;
      end
      if (i == 11) req_valid_i = 2'b00;
      cyc();
    end
    check("rr_num_grants", n_gr, 4);
    check("rr_num_wb", n_wb, 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rr_grant%0d", j), gr[j], (j % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_src%0d", j), src_q[j], (j % 2 == 0) ? 1'b0 : 1'b1);
      check($sformatf("rr_data%0d", j), dat_q[j],
            (j % 2 == 0) ? splat(32'd3) : splat(32'd30));
    end
    check("rr_count", op_count_o, 32'd6);
    check("rr_idle", busy_o, 0);

    // WB stall: slot1 VADD 0x7FFFFFFF + 1, ready low for 5 WB cycles
    wb_ready_i = 1'b0;
    set_slot(1, 5'd1, 32'h7FFF_FFFF, 32'd1, 5'd7);
    req_valid_i = 2'b10;
    #1;
    check("stall_ready", req_ready_o, 2'b10);
    cyc();
    set_slot(0, 5'd2, 32'd3, 32'd4, 5'd2);
    req_valid_i = 2'b01;
    #1;
    check("stall_exec_op", alu_opcode_o, 5'd1);
    check("stall_exec_ready", req_ready_o, 2'b00);
    cyc();
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d_valid", s), wb_valid_o, 1);
      check($sformatf("stall%0d_data", s), wb_data_o, splat(32'h8000_0000));
      check($sformatf("stall%0d_vd", s), wb_vd_o, 5'd7);
      check($sformatf("stall%0d_src", s), wb_src_o, 1'b1);
      check($sformatf("stall%0d_ready", s), req_ready_o, 2'b00);
      check($sformatf("stall%0d_busy", s), busy_o, 1);
      cyc();
    end
    wb_ready_i = 1'b1;
    #1;
    check("stall_accept_valid", wb_valid_o, 1);
    check("stall_accept_data", wb_data_o, splat(32'h8000_0000));
    cyc();
    check("stall_count", op_count_o, 32'd7);
    check("stall_idle_busy", busy_o, 0);
    check("stall_next_ready", req_ready_o, 2'b01);

    // Reset during the first EXEC cycle of slot0's VMUL
    cyc();
    check("rstx_exec_op", alu_opcode_o, 5'd2);
    check("rstx_exec_v1", alu_v1_o, splat(32'd3));
    rst = 1'b0;
    #1;
    check("rstx_busy", busy_o, 0);
    check("rstx_aluop", alu_opcode_o, 5'd0);
    check("rstx_aluv1", alu_v1_o, 256'd0);
    check("rstx_wb_valid", wb_valid_o, 0);
    check("rstx_wb_data", wb_data_o, 256'd0);
    check("rstx_wb_vd", wb_vd_o, 5'd0);
    check("rstx_wb_src", wb_src_o, 1'b0);
    check("rstx_count", op_count_o, 32'd0);
    check("rstx_ready", req_ready_o, 2'b00);
    cyc();
    check("rstx_hold_wbv", wb_valid_o, 0);
    check("rstx_hold_busy", busy_o, 0);
    rst = 1'b1;
    set_slot(0, 5'd1, 32'd2, 32'd3, 5'd1);
    req_valid_i = 2'b11;
    #1;
    check("rstx_ptr_grant", req_ready_o, 2'b01);
    cyc();
    req_valid_i = 2'b00;
    cyc();
    check("rstx_wb_valid2", wb_valid_o, 1);
    check("rstx_wb_data2", wb_data_o, splat(32'd5));
    check("rstx_wb_src2", wb_src_o, 1'b0);
    cyc();
    check("rstx_count2", op_count_o, 32'd1);

    // Unknown opcode 9 on slot1: ADD_LAT hold, result 0, still counted
    set_slot(1, 5'd9, 32'd6, 32'd6, 5'd11);
    req_valid_i = 2'b10;
    #1;
    check("unk_ready", req_ready_o, 2'b10);
    cyc();
    req_valid_i = 2'b00;
    #1;
    check("unk_exec_op", alu_opcode_o, 5'd9);
    cyc();
    check("unk_wb_valid", wb_valid_o, 1);
    check("unk_wb_data", wb_data_o, 256'd0);
    check("unk_wb_src", wb_src_o, 1'b1);
    check("unk_wb_vd", wb_vd_o, 5'd11);
    cyc();
    check("unk_count", op_count_o, 32'd2);
    check("unk_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
